moore_run_arbiter: RTL and testbench

Scheduler that shares one two-flip-flop toggle-counter Moore datapath between two requesters. The datapath has inputs x_in, clock and an active-low reset, and outputs y_out = A & B with state bits A and B. Each requester asks for a run of `len` counting pulses. The block arbitrates round-robin, clears the datapath, drives x_in for exactly `len` cycles, counts y_out hits, and returns the result with a one-cycle done pulse. It sits between requester logic and the datapath and is the only driver of the datapath's x_in and reset.

---
 rtl/moore_run_arbiter_if.sv | 28 ++
 rtl/moore_run_arbiter.sv | 137 +++++++++++++
 tb/tb_moore_run_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/moore_run_arbiter_if.sv
// Bundle between the requesters, the shared toggle-counter datapath and the run arbiter.
// The master side is the environment (requesters plus datapath); the slave side is the arbiter.
interface moore_run_arbiter_if #(
    parameter int LEN_W = 4
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             y_in;
    logic [1:0]       ab_in;
    logic             x_out;
    logic             dp_rst_b;
    logic [1:0]       grant;
    logic             busy;
    logic [1:0]       done;
    logic [LEN_W-1:0] hits;
    logic [1:0]       final_ab;

    modport master (
        output req, len0, len1, y_in, ab_in,
        input  x_out, dp_rst_b, grant, busy, done, hits, final_ab
    );

    modport slave (
        input  req, len0, len1, y_in, ab_in,
        output x_out, dp_rst_b, grant, busy, done, hits, final_ab
    );
endinterface

// File: rtl/moore_run_arbiter.sv
// Round-robin scheduler sharing one toggle-counter Moore datapath between two requesters.
//   state   | meaning
//   S_IDLE  | datapath out of reset, waiting for a request
//   S_CLEAR | one cycle holding the datapath in reset
//   S_RUN   | x_out high, counting y_in hits for len cycles
//   S_DONE  | done pulse to the owner, final_ab captured
module moore_run_arbiter #(
    parameter int LEN_W = 4
) (
    input logic               clock,
    input logic               reset,
    moore_run_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             ptr;
    logic             owner;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] hits_q;
    logic [1:0]       final_ab_q;

    logic             x_out_q;
    logic             dp_rst_b_q;
    logic [1:0]       grant_q;
    logic             busy_q;
    logic [1:0]       done_q;

    logic             grant_take;
    logic             win_sel;
    logic             owner_eff;

    function automatic logic [1:0] onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_take = 1'b0;
        win_sel    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    grant_take = 1'b1;
                    win_sel    = (bus.req == 2'b11) ? ptr : bus.req[1];
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_next = (cnt != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                // terminal count: the cycle that sees 1 is the last RUN cycle
                if (cnt <= LEN_W'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign owner_eff = grant_take ? win_sel : owner;

    // Run bookkeeping: length down-counter, hit counter and captured datapath state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            cnt        <= '0;
            hits_q     <= '0;
            final_ab_q <= 2'b00;
        end else begin
            if (grant_take) begin
                owner  <= win_sel;
                ptr    <= ~win_sel;
                cnt    <= win_sel ? bus.len1 : bus.len0;
                hits_q <= '0;
            end
            if (state == S_RUN) begin
                cnt <= cnt - LEN_W'(1);
                if (bus.y_in && (hits_q != '1)) begin
                    hits_q <= hits_q + LEN_W'(1);
                end
            end
            if (state == S_DONE) begin
                final_ab_q <= bus.ab_in;
            end
        end
    end

    // Outputs are registered from the next state so reset forces them directly
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_out_q    <= 1'b0;
            dp_rst_b_q <= 1'b0;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 2'b00;
        end else begin
            x_out_q    <= (state_next == S_RUN);
            dp_rst_b_q <= (state_next != S_CLEAR);
            busy_q     <= (state_next != S_IDLE);
            grant_q    <= (state_next == S_IDLE) ? 2'b00 : onehot(owner_eff);
            done_q     <= (state_next == S_DONE) ? onehot(owner_eff) : 2'b00;
        end
    end

    assign bus.x_out    = x_out_q;
    assign bus.dp_rst_b = dp_rst_b_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hits     = hits_q;
    assign bus.final_ab = final_ab_q;

endmodule

// File: tb/tb_moore_run_arbiter.sv
// Bench for moore_run_arbiter with a behavioural toggle-counter datapath attached.
module tb_moore_run_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] ab = 2'b00;

    int n_chk  = 0;
    int n_fail = 0;
    logic ptr_m = 1'b0;

    moore_run_arbiter_if #(.LEN_W(4)) bus ();

    moore_run_arbiter #(.LEN_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Two flip-flop toggle counter: advances on x, y = A & B, async active-low clear
    always @(posedge clock or negedge bus.dp_rst_b) begin
        if (!bus.dp_rst_b) ab <= 2'b00;
        else if (bus.x_out) ab <= ab + 2'b01;
    end
    assign bus.ab_in = ab;
    assign bus.y_in  = ab[1] & ab[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the arbiter idle; returns at the negedge of the IDLE after DONE.
    task automatic do_run(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                          input bit hold);
        logic       win;
        logic [1:0] oh;
        int         len;
        int         cyc;
        int         xcnt;
        win   = (r == 2'b11) ? ptr_m : r[1];
        ptr_m = ~win;
        len   = win ? int'(l1) : int'(l0);
        oh    = win ? 2'b10 : 2'b01;
        bus.req  = r;
        bus.len0 = l0;
        bus.len1 = l1;
        @(negedge clock);
        chk("grant_clear", 32'(bus.grant), 32'(oh));
        chk("busy_clear", 32'(bus.busy), 1);
        chk("dprst_clear", 32'(bus.dp_rst_b), 0);
        chk("x_clear", 32'(bus.x_out), 0);
        chk("hits_clear", 32'(bus.hits), 0);
        cyc  = 0;
        xcnt = 0;
        while (bus.done == 2'b00 && cyc < 40) begin
            bus.len0 = 4'($urandom);
            bus.len1 = 4'($urandom);
            if (!hold) bus.req = 2'b00;
            @(negedge clock);
            cyc++;
            if (bus.x_out) xcnt++;
            chk("dprst_run", 32'(bus.dp_rst_b), 1);
        end
        chk("run_len", 32'(cyc), 32'(len + 1));
        chk("x_cycles", 32'(xcnt), 32'(len));
        chk("done", 32'(bus.done), 32'(oh));
        chk("grant_done", 32'(bus.grant), 32'(oh));
        chk("hits", 32'(bus.hits), 32'(len / 4));
        @(negedge clock);
        chk("done_pulse", 32'(bus.done), 0);
        chk("final_ab", 32'(bus.final_ab), 32'(len % 4));
        chk("hits_hold", 32'(bus.hits), 32'(len / 4));
        chk("busy_idle", 32'(bus.busy), 0);
        chk("grant_idle", 32'(bus.grant), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         hold;
        logic [1:0] r;
        int         gap;
        bus.req  = 2'b00;
        bus.len0 = 4'd0;
        bus.len1 = 4'd0;
        #12;
        chk("rst_x", 32'(bus.x_out), 0);
        chk("rst_dprst", 32'(bus.dp_rst_b), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_hits", 32'(bus.hits), 0);
        chk("rst_final_ab", 32'(bus.final_ab), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_dprst", 32'(bus.dp_rst_b), 1);

        do_run(2'b01, 4'd7, 4'd0, 1'b0);

        for (int i = 0; i < 4; i++) do_run(2'b11, 4'd4, 4'd8, (i < 3));

        do_run(2'b10, 4'd0, 4'd0, 1'b0);
        do_run(2'b01, 4'd15, 4'd0, 1'b0);

        bus.req  = 2'b01;
        bus.len0 = 4'd12;
        @(negedge clock);
        bus.req = 2'b00;
        repeat (4) @(negedge clock);
        chk("mid_run_x", 32'(bus.x_out), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_x", 32'(bus.x_out), 0);
        chk("arst_dprst", 32'(bus.dp_rst_b), 0);
        chk("arst_grant", 32'(bus.grant), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_hits", 32'(bus.hits), 0);
        chk("arst_final_ab", 32'(bus.final_ab), 0);
        chk("arst_ab", 32'(ab), 0);
        repeat (2) begin
            @(negedge clock);
            chk("arst_no_done", 32'(bus.done), 0);
        end
        reset = 1'b0;
        ptr_m = 1'b0;
        @(negedge clock);
        do_run(2'b01, 4'd5, 4'd0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            r    = 2'($urandom_range(1, 3));
            hold = ($urandom_range(0, 1) == 1) && (i < 29);
            do_run(r, 4'($urandom), 4'($urandom), hold);
            if (!hold) begin
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clock);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
